video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed 384×264 pixel/line divider chain in the video section.
- Produces pixel and line counters, pixel-clock divider taps, HSYNC/VSYNC, blanking, a field flag, line/frame start strobes and a raster-compare interrupt.
- Clocked by the pixel master clock and advanced by a clock enable, so one instance serves 6 MHz or divided-clock variants.
- Feeds the LSPC-side fetch sequencer, sync output and CPU interrupt logic.

Parameters:
- H_W, 9, pixel counter width.
- V_W, 9, line counter width.
- H_TOTAL, 384, pixels per line (counter wraps at H_TOTAL-1).
- V_TOTAL, 264, lines per frame.
- H_SYNC_START, 0, first pixel with HSYNC asserted.
- H_SYNC_LEN, 32, HSYNC width in pixels.
- H_ACT_START, 56, first active pixel.
- H_ACT_END, 376, first blanked pixel after the active region.
- V_SYNC_START, 0, first VSYNC line.
- V_SYNC_LEN, 8, VSYNC height in lines.
- V_ACT_START, 16, first active line.
- V_ACT_END, 240, first blanked line after the active region.
- H_IRQ_POS, 0, pixel at which the raster compare is evaluated.

Ports:
- CLK  in  1  pixel master clock.
- RESET  in  1  asynchronous, active-high reset.
- CE  in  1  pixel advance enable; all state holds when low.
- H_CNT  out  H_W  current pixel.
- V_CNT  out  V_W  current line.
- DIV  out  7  divider taps, equal to H_CNT[6:0].
- HSYNC  out  1  active-high horizontal sync.
- VSYNC  out  1  active-high vertical sync.
- HBLANK  out  1  high outside [H_ACT_START, H_ACT_END).
- VBLANK  out  1  high outside [V_ACT_START, V_ACT_END).
- ACTIVE  out  1  ~HBLANK & ~VBLANK.
- LINE_START  out  1  high while H_CNT==0.
- FRAME_START  out  1  high while H_CNT==0 and V_CNT==0.
- FIELD  out  1  toggles on each frame wrap.
- CMP_WR  in  1  load pending compare line.
- CMP_EN_IN  in  1  pending compare enable, loaded with CMP_WR.
- CMP_LINE  in  V_W  pending compare line, loaded with CMP_WR.
- IRQ_ACK  in  1  clears RASTER_IRQ.
- RASTER_IRQ  out  1  sticky raster-compare interrupt.

Behaviour:
- CLK and RESET are the only clock and reset. RESET is asynchronous and active-high.
- Reset values: H_CNT=0, V_CNT=0, FIELD=0, RASTER_IRQ=0, pending and active compare registers = 0 with enable 0.
- Decoded outputs at reset therefore read: HSYNC=1, VSYNC=1, HBLANK=1, VBLANK=1, ACTIVE=0, LINE_START=1, FRAME_START=1.
- Counters: on CLK rising edge with CE=1:
  - H_CNT increments.
  - At H_CNT==H_TOTAL-1, H_CNT returns to 0 and V_CNT increments.
  - At V_CNT==V_TOTAL-1 on that same edge, V_CNT returns to 0 and FIELD toggles.
  - With CE=0, no register changes except the CMP_WR load and the IRQ_ACK clear, which are CE-independent.
- Decodes: all outputs except RASTER_IRQ are combinational from the registered counters, giving zero latency relative to H_CNT/V_CNT.
  - HSYNC = H_CNT in [H_SYNC_START, H_SYNC_START+H_SYNC_LEN).
  - VSYNC = V_CNT in [V_SYNC_START, V_SYNC_START+V_SYNC_LEN).
  - All windows are half-open and non-wrapping; the parameter check requires start+len ≤ total.
- Compare double-buffering:
  - CMP_WR=1 loads CMP_LINE/CMP_EN_IN into the pending register on the same edge.
  - Pending copies to active at every frame wrap edge (CE=1, H_CNT==H_TOTAL-1, V_CNT==V_TOTAL-1).
  - If CMP_WR coincides with the frame wrap edge, the new value goes straight to active.
  - The last CMP_WR before the wrap wins.
- IRQ:
  - Set condition: CE=1, active enable=1, V_CNT==active line, H_CNT==H_IRQ_POS.
  - RASTER_IRQ is registered; it rises one CLK after that condition is sampled.
  - It stays high until IRQ_ACK.
  - If set and IRQ_ACK occur on the same edge, set wins.
  - A compare line ≥ V_TOTAL never fires.
- Mid-frame RESET: all counters return to 0 asynchronously and the next frame starts cleanly. A pending compare is lost.
- Elaboration: H_W/V_W must cover H_TOTAL-1/V_TOTAL-1. H_W must be ≥ 7 for DIV.

Test Plan:
- Reset, then 101376 CE cycles (384×264) → FRAME_START high at cycle 0 and at cycle 101376. FIELD toggles once. V_CNT reaches 263 and wraps.
- CE toggled 1-of-2 → counters advance every 2nd CLK. One line = 768 CLKs. DIV[0] period = 4 CLKs.
- Line 20, default parameters:
  - HSYNC high for H_CNT 0–31.
  - HBLANK low for H_CNT 56–375.
  - ACTIVE high there.
  - VBLANK low for lines 16–239; VSYNC high for lines 0–7.
- CMP_WR with line 100, enable 1, during frame N → no IRQ in frame N. In frame N+1, RASTER_IRQ rises 1 CLK after V_CNT=100, H_CNT=0 and holds until IRQ_ACK. IRQ_ACK on the same cycle as the next set leaves it high.
- CMP_WR exactly on the frame wrap edge with line 3 → IRQ at line 3 of the immediately following frame. Two writes in one frame (50, then 60) → only line 60 fires.
- RESET asserted at V_CNT=150, H_CNT=200 → H_CNT/V_CNT=0 immediately, RASTER_IRQ=0, FIELD=0, compare disabled.

Source files
------------

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, sync/blank decodes,
// field flag and a double-buffered raster-compare interrupt.
module video_timing_gen #(
    parameter int H_W          = 9,
    parameter int V_W          = 9,
    parameter int H_TOTAL      = 384,
    parameter int V_TOTAL      = 264,
    parameter int H_SYNC_START = 0,
    parameter int H_SYNC_LEN   = 32,
    parameter int H_ACT_START  = 56,
    parameter int H_ACT_END    = 376,
    parameter int V_SYNC_START = 0,
    parameter int V_SYNC_LEN   = 8,
    parameter int V_ACT_START  = 16,
    parameter int V_ACT_END    = 240,
    parameter int H_IRQ_POS    = 0
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           CE,
    output logic [H_W-1:0] H_CNT,
    output logic [V_W-1:0] V_CNT,
    output logic [6:0]     DIV,
    output logic           HSYNC,
    output logic           VSYNC,
    output logic           HBLANK,
    output logic           VBLANK,
    output logic           ACTIVE,
    output logic           LINE_START,
    output logic           FRAME_START,
    output logic           FIELD,
    input  logic           CMP_WR,
    input  logic           CMP_EN_IN,
    input  logic [V_W-1:0] CMP_LINE,
    input  logic           IRQ_ACK,
    output logic           RASTER_IRQ
);

    localparam bit LP_BAD =
        (H_W < 7) || (H_TOTAL < 1) || (V_TOTAL < 1) ||
        (H_TOTAL - 1 >= (1 << H_W)) || (V_TOTAL - 1 >= (1 << V_W)) ||
        (H_SYNC_START + H_SYNC_LEN > H_TOTAL) || (V_SYNC_START + V_SYNC_LEN > V_TOTAL) ||
        (H_ACT_START > H_ACT_END) || (H_ACT_END > H_TOTAL) ||
        (V_ACT_START > V_ACT_END) || (V_ACT_END > V_TOTAL) ||
        (H_IRQ_POS >= H_TOTAL);

    if (LP_BAD) begin : g_param_check
        $error("video_timing_gen: invalid timing parameters");
    end

    localparam logic [H_W-1:0] LP_H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] LP_V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] LP_H_IRQ    = H_W'(H_IRQ_POS);
    localparam logic [H_W-1:0] LP_HS_START = H_W'(H_SYNC_START);
    localparam logic [H_W:0]   LP_HS_LEN   = (H_W+1)'(H_SYNC_LEN);
    localparam logic [H_W-1:0] LP_HA_START = H_W'(H_ACT_START);
    localparam logic [H_W:0]   LP_HA_LEN   = (H_W+1)'(H_ACT_END - H_ACT_START);
    localparam logic [V_W-1:0] LP_VS_START = V_W'(V_SYNC_START);
    localparam logic [V_W:0]   LP_VS_LEN   = (V_W+1)'(V_SYNC_LEN);
    localparam logic [V_W-1:0] LP_VA_START = V_W'(V_ACT_START);
    localparam logic [V_W:0]   LP_VA_LEN   = (V_W+1)'(V_ACT_END - V_ACT_START);

    logic [H_W-1:0] r_h;
    logic [V_W-1:0] r_v;
    logic           r_field;
    logic           r_pend_en;
    logic [V_W-1:0] r_pend_line;
    logic           r_act_en;
    logic [V_W-1:0] r_act_line;
    logic           r_irq;

    logic           w_h_last;
    logic           w_v_last;
    logic           w_frame_wrap;
    logic           w_irq_set;
    logic [H_W-1:0] w_hs_off;
    logic [H_W-1:0] w_ha_off;
    logic [V_W-1:0] w_vs_off;
    logic [V_W-1:0] w_va_off;

    assign w_h_last     = (r_h == LP_H_LAST);
    assign w_v_last     = (r_v == LP_V_LAST);
    assign w_frame_wrap = CE & w_h_last & w_v_last;
    assign w_irq_set    = CE & r_act_en & (r_v == r_act_line) & (r_h == LP_H_IRQ);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_h     <= '0;
            r_v     <= '0;
            r_field <= 1'b0;
        end else if (CE) begin
            if (w_h_last) begin
                r_h <= '0;
                if (w_v_last) begin
                    r_v     <= '0;
                    r_field <= ~r_field;
                end else begin
                    r_v <= r_v + 1'b1;
                end
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // A write landing on the frame-wrap edge bypasses pending straight into active.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pend_en   <= 1'b0;
            r_pend_line <= '0;
            r_act_en    <= 1'b0;
            r_act_line  <= '0;
        end else begin
            if (CMP_WR) begin
                r_pend_en   <= CMP_EN_IN;
                r_pend_line <= CMP_LINE;
            end
            if (w_frame_wrap) begin
                r_act_en   <= CMP_WR ? CMP_EN_IN : r_pend_en;
                r_act_line <= CMP_WR ? CMP_LINE  : r_pend_line;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (IRQ_ACK) begin
            r_irq <= 1'b0;
        end
    end

    // Window test as (cnt - start) < len: below-start values wrap high and fall outside.
    assign w_hs_off = r_h - LP_HS_START;
    assign w_ha_off = r_h - LP_HA_START;
    assign w_vs_off = r_v - LP_VS_START;
    assign w_va_off = r_v - LP_VA_START;

    assign H_CNT       = r_h;
    assign V_CNT       = r_v;
    assign DIV         = r_h[6:0];
    assign HSYNC       = ({1'b0, w_hs_off} < LP_HS_LEN);
    assign VSYNC       = ({1'b0, w_vs_off} < LP_VS_LEN);
    assign HBLANK      = ~({1'b0, w_ha_off} < LP_HA_LEN);
    assign VBLANK      = ~({1'b0, w_va_off} < LP_VA_LEN);
    assign ACTIVE      = ~HBLANK & ~VBLANK;
    assign LINE_START  = (r_h == '0);
    assign FRAME_START = (r_h == '0) && (r_v == '0);
    assign FIELD       = r_field;
    assign RASTER_IRQ  = r_irq;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced 64x24 raster so whole
// frames, wraps and compare double-buffering run in a short simulation.
module tb_video_timing_gen;

    localparam int HW  = 9;
    localparam int VW  = 9;
    localparam int HT  = 64;
    localparam int VT  = 24;
    localparam int HSS = 2;
    localparam int HSL = 8;
    localparam int HAS = 12;
    localparam int HAE = 60;
    localparam int VSS = 1;
    localparam int VSL = 2;
    localparam int VAS = 4;
    localparam int VAE = 20;
    localparam int HIP = 5;
    localparam int FRAME = HT * VT;

    localparam int S_H = 0, S_V = 1, S_DIV = 2, S_HS = 3, S_VS = 4, S_HB = 5;
    localparam int S_VB = 6, S_ACT = 7, S_LS = 8, S_FS = 9, S_FLD = 10, S_IRQ = 11;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          CE = 1'b0;
    logic [HW-1:0] H_CNT;
    logic [VW-1:0] V_CNT;
    logic [6:0]    DIV;
    logic          HSYNC, VSYNC, HBLANK, VBLANK, ACTIVE;
    logic          LINE_START, FRAME_START, FIELD;
    logic          CMP_WR = 1'b0;
    logic          CMP_EN_IN = 1'b0;
    logic [VW-1:0] CMP_LINE = '0;
    logic          IRQ_ACK = 1'b0;
    logic          RASTER_IRQ;

    video_timing_gen #(
        .H_W(HW), .V_W(VW), .H_TOTAL(HT), .V_TOTAL(VT),
        .H_SYNC_START(HSS), .H_SYNC_LEN(HSL), .H_ACT_START(HAS), .H_ACT_END(HAE),
        .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .V_ACT_START(VAS), .V_ACT_END(VAE),
        .H_IRQ_POS(HIP)
    ) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE),
        .H_CNT(H_CNT), .V_CNT(V_CNT), .DIV(DIV),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .HBLANK(HBLANK), .VBLANK(VBLANK), .ACTIVE(ACTIVE),
        .LINE_START(LINE_START), .FRAME_START(FRAME_START), .FIELD(FIELD),
        .CMP_WR(CMP_WR), .CMP_EN_IN(CMP_EN_IN), .CMP_LINE(CMP_LINE),
        .IRQ_ACK(IRQ_ACK), .RASTER_IRQ(RASTER_IRQ)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int    sig;
        int    exp;
        string name;
    } chk_t;

    chk_t q[$];
    chk_t m_e;
    int   m_act;
    int   n_chk = 0;
    int   n_pass = 0;
    int   pos = 0;

    function automatic int sample(input int s);
        case (s)
            S_H:     return int'(H_CNT);
            S_V:     return int'(V_CNT);
            S_DIV:   return int'(DIV);
            S_HS:    return int'(HSYNC);
            S_VS:    return int'(VSYNC);
            S_HB:    return int'(HBLANK);
            S_VB:    return int'(VBLANK);
            S_ACT:   return int'(ACTIVE);
            S_LS:    return int'(LINE_START);
            S_FS:    return int'(FRAME_START);
            S_FLD:   return int'(FIELD);
            S_IRQ:   return int'(RASTER_IRQ);
            default: return -1;
        endcase
    endfunction

    always @(negedge CLK) begin
        while (q.size() != 0) begin
            m_e   = q.pop_front();
            m_act = sample(m_e.sig);
            n_chk++;
            if (m_act == m_e.exp) n_pass++;
            else $display("FAIL %s: got %0d expected %0d (t=%0t)", m_e.name, m_act, m_e.exp, $time);
        end
    end

    task automatic expect_v(input int sig, input int exp, input string name);
        chk_t e;
        e.sig = sig; e.exp = exp; e.name = name;
        q.push_back(e);
    endtask

    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic adv(input int n);
        CE = 1'b1;
        repeat (n) tick();
        CE = 1'b0;
        pos += n;
    endtask

    task automatic goto_hv(input int h, input int v);
        int d;
        d = ((v * HT + h) - (pos % FRAME) + FRAME) % FRAME;
        if (d != 0) adv(d);
    endtask

    task automatic cmp_write(input int line, input bit en);
        CMP_LINE = VW'(line); CMP_EN_IN = en; CMP_WR = 1'b1;
        tick();
        CMP_WR = 1'b0;
    endtask

    task automatic ack();
        IRQ_ACK = 1'b1;
        tick();
        IRQ_ACK = 1'b0;
    endtask

    function automatic int exp_field();
        return (pos / FRAME) % 2;
    endfunction

    initial begin
        repeat (2) tick();
        expect_v(S_H, 0, "rst_h"); expect_v(S_V, 0, "rst_v");
        expect_v(S_FLD, 0, "rst_field"); expect_v(S_IRQ, 0, "rst_irq");
        expect_v(S_HS, 0, "rst_hsync"); expect_v(S_VS, 0, "rst_vsync");
        expect_v(S_HB, 1, "rst_hblank"); expect_v(S_VB, 1, "rst_vblank");
        expect_v(S_ACT, 0, "rst_active"); expect_v(S_LS, 1, "rst_line_start");
        expect_v(S_FS, 1, "rst_frame_start");
        settle();
        RESET = 1'b0;
        tick();

        // CE high on every second clock: a line takes 2*HT clocks.
        for (int i = 0; i < 2 * HT; i++) begin
            CE = (i % 2 == 0);
            tick();
            if (i == 19) begin expect_v(S_H, 10, "ce_half_h"); expect_v(S_DIV, 10, "ce_half_div"); settle(); end
            if (i == 21) begin expect_v(S_H, 11, "ce_hold"); settle(); end
        end
        CE = 1'b0;
        pos += HT;
        expect_v(S_H, 0, "ce_half_line_h"); expect_v(S_V, 1, "ce_half_line_v");
        settle();

        goto_hv(0, 6);
        for (int h = 0; h < HT; h++) begin
            expect_v(S_H, h, "scan_h");
            expect_v(S_DIV, h & 127, "scan_div");
            expect_v(S_HS, int'(h >= HSS && h < HSS + HSL), "scan_hsync");
            expect_v(S_HB, int'(!(h >= HAS && h < HAE)), "scan_hblank");
            expect_v(S_ACT, int'(h >= HAS && h < HAE), "scan_active");
            settle();
            adv(1);
        end

        goto_hv(HT - 1, VT - 1);
        expect_v(S_H, HT - 1, "last_h"); expect_v(S_V, VT - 1, "last_v");
        expect_v(S_FLD, 0, "field_before_wrap");
        settle();
        adv(1);
        expect_v(S_H, 0, "wrap_h"); expect_v(S_V, 0, "wrap_v");
        expect_v(S_FLD, 1, "field_after_wrap"); expect_v(S_FS, 1, "wrap_frame_start");
        settle();

        for (int v = 0; v < VT; v++) begin
            expect_v(S_V, v, "vscan_v");
            expect_v(S_VS, int'(v >= VSS && v < VSS + VSL), "vscan_vsync");
            expect_v(S_VB, int'(!(v >= VAS && v < VAE)), "vscan_vblank");
            expect_v(S_LS, 1, "vscan_line_start");
            expect_v(S_FS, int'(v == 0), "vscan_frame_start");
            settle();
            adv(HT);
        end
        expect_v(S_FLD, 0, "field_second_wrap"); expect_v(S_FS, 1, "frame_start_again");
        settle();

        // Compare written mid-frame takes effect only from the next frame.
        cmp_write(10, 1'b1);
        goto_hv(HIP, 10); adv(1);
        expect_v(S_IRQ, 0, "irq_same_frame"); settle();
        goto_hv(HIP, 10);
        expect_v(S_IRQ, 0, "irq_before_edge"); settle();
        adv(1);
        expect_v(S_IRQ, 1, "irq_rise"); settle();
        adv(100);
        expect_v(S_IRQ, 1, "irq_sticky"); settle();
        ack();
        expect_v(S_IRQ, 0, "irq_ack"); settle();
        goto_hv(HIP, 10);
        IRQ_ACK = 1'b1;
        adv(1);
        IRQ_ACK = 1'b0;
        expect_v(S_IRQ, 1, "irq_set_beats_ack"); settle();
        ack();

        goto_hv(HT - 1, VT - 1);
        CMP_LINE = 3; CMP_EN_IN = 1'b1; CMP_WR = 1'b1;
        adv(1);
        CMP_WR = 1'b0;
        goto_hv(HIP, 3);
        expect_v(S_IRQ, 0, "wrap_wr_pre"); settle();
        adv(1);
        expect_v(S_IRQ, 1, "wrap_wr_fire"); settle();
        ack();

        cmp_write(7, 1'b1);
        goto_hv(30, 10);
        cmp_write(9, 1'b1);
        goto_hv(HIP, 7); adv(1);
        expect_v(S_IRQ, 0, "two_wr_first_lost"); settle();
        goto_hv(HIP, 9); adv(1);
        expect_v(S_IRQ, 1, "two_wr_last_wins"); settle();
        ack();

        cmp_write(30, 1'b1);
        adv(2 * FRAME);
        expect_v(S_IRQ, 0, "line_out_of_range"); settle();

        // Mid-frame reset drops both pending and active compare state.
        goto_hv(HT - 1, VT - 1);
        CMP_LINE = 2; CMP_EN_IN = 1'b1; CMP_WR = 1'b1;
        adv(1);
        CMP_WR = 1'b0;
        goto_hv(HIP, 2); adv(1);
        expect_v(S_IRQ, 1, "pre_reset_irq"); settle();
        cmp_write(12, 1'b1);
        goto_hv(40, 15);
        expect_v(S_H, 40, "pre_reset_h"); expect_v(S_V, 15, "pre_reset_v");
        expect_v(S_FLD, exp_field(), "pre_reset_field");
        settle();
        #2;
        RESET = 1'b1;
        #1;
        expect_v(S_H, 0, "mid_reset_h"); expect_v(S_V, 0, "mid_reset_v");
        expect_v(S_IRQ, 0, "mid_reset_irq"); expect_v(S_FLD, 0, "mid_reset_field");
        settle();
        RESET = 1'b0;
        pos = 0;
        tick();
        for (int f = 0; f < 2; f++) begin
            goto_hv(HIP, 2); adv(1);
            expect_v(S_IRQ, 0, "post_reset_line2"); settle();
            goto_hv(HIP, 12); adv(1);
            expect_v(S_IRQ, 0, "post_reset_line12"); settle();
        end
        expect_v(S_FLD, exp_field(), "post_reset_field");
        expect_v(S_V, 12, "post_reset_v");
        settle();

        settle();
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
            n_chk += q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
